// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// core_pkg : shared widths, reset vector, opcodes and IFU state encoding
// Revision : 1.0
// ============================================================================
package core_pkg;

  localparam int          ADDR_WIDTH = 32;
  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h8000_0000;
  localparam logic [31:0] INST_NOP   = 32'h0000_0013;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } ifu_state_e;

endpackage
`default_nettype wire

// File: rtl/ifu_fetch.sv
`default_nettype none
// ============================================================================
// ifu_fetch : PC owner, one imem read per instruction, valid/ready to ifu2idu
// Revision  : 1.0
// ============================================================================
module ifu_fetch
  import core_pkg::*;
#(
  parameter int                    ADDR_WIDTH = core_pkg::ADDR_WIDTH,
  parameter int                    DATA_WIDTH = core_pkg::DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = core_pkg::RESET_PC
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst_n,
  output logic                  o_ifu_arvalid,
  input  logic                  i_mem_arready,
  output logic [ADDR_WIDTH-1:0] o_ifu_araddr,
  input  logic                  i_mem_rvalid,
  output logic                  o_ifu_rready,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic [1:0]            i_mem_rresp,
  output logic                  o_ifu_valid,
  input  logic                  i_i2i_ready,
  output logic [ADDR_WIDTH-1:0] o_ifu_pc,
  output logic [DATA_WIDTH-1:0] o_ifu_inst,
  output logic                  o_ifu_err,
  input  logic                  i_exu_jmp_en,
  input  logic [ADDR_WIDTH-1:0] i_exu_jmp_pc
);

  ifu_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_kill;
  logic                  r_arvalid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_rready;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_out_pc;
  logic [DATA_WIDTH-1:0] r_inst;
  logic                  r_err;

  // A redirect always wins over the current PC / sequential successor.
  logic [ADDR_WIDTH-1:0] w_refetch_pc;
  logic [ADDR_WIDTH-1:0] w_next_pc;

  assign w_refetch_pc = i_exu_jmp_en ? i_exu_jmp_pc : r_pc;
  assign w_next_pc    = i_exu_jmp_en ? i_exu_jmp_pc : r_pc + ADDR_WIDTH'(4);

  always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_kill    <= 1'b0;
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_rready  <= 1'b0;
      r_valid   <= 1'b0;
      r_out_pc  <= '0;
      r_inst    <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state   <= AR;
          r_arvalid <= 1'b1;
          r_araddr  <= w_refetch_pc;
          r_pc      <= w_refetch_pc;
        end
        AR: begin
          if (i_mem_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= R;
            // The old address is already accepted; its response must be dropped.
            if (i_exu_jmp_en) begin
              r_kill <= 1'b1;
              r_pc   <= i_exu_jmp_pc;
            end
          end else if (i_exu_jmp_en) begin
            r_pc     <= i_exu_jmp_pc;
            r_araddr <= i_exu_jmp_pc;
          end
        end
        R: begin
          if (i_mem_rvalid) begin
            r_rready <= 1'b0;
            if (r_kill || i_exu_jmp_en) begin
              r_kill    <= 1'b0;
              r_state   <= AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_refetch_pc;
              r_pc      <= w_refetch_pc;
            end else begin
              r_state  <= OUT;
              r_valid  <= 1'b1;
              r_out_pc <= r_pc;
              r_err    <= (i_mem_rresp != RESP_OKAY);
              r_inst   <= (i_mem_rresp != RESP_OKAY) ? DATA_WIDTH'(INST_NOP) : i_mem_rdata;
            end
          end else if (i_exu_jmp_en) begin
            r_kill <= 1'b1;
            r_pc   <= i_exu_jmp_pc;
          end
        end
        OUT: begin
          if (i_exu_jmp_en || i_i2i_ready) begin
            r_valid   <= 1'b0;
            r_state   <= AR;
            r_arvalid <= 1'b1;
            r_araddr  <= w_next_pc;
            r_pc      <= w_next_pc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ifu_arvalid = r_arvalid;
  assign o_ifu_araddr  = r_araddr;
  assign o_ifu_rready  = r_rready;
  assign o_ifu_valid   = r_valid;
  assign o_ifu_pc      = r_out_pc;
  assign o_ifu_inst    = r_inst;
  assign o_ifu_err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
// ============================================================================
// tb_ifu_fetch : randomized imem/downstream/redirect stimulus with scoreboard
// Revision     : 1.0
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] C_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;
  localparam logic [31:0] C_DEAD     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arvalid, arready, rvalid, rready, valid, i2i_ready, err, jmp_en;
  logic [31:0] araddr, rdata, pc, inst, jmp_pc;
  logic [1:0]  rresp;

  always #5 clk = ~clk;

  ifu_fetch dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .o_ifu_arvalid(arvalid),
    .i_mem_arready(arready),
    .o_ifu_araddr (araddr),
    .i_mem_rvalid (rvalid),
    .o_ifu_rready (rready),
    .i_mem_rdata  (rdata),
    .i_mem_rresp  (rresp),
    .o_ifu_valid  (valid),
    .i_i2i_ready  (i2i_ready),
    .o_ifu_pc     (pc),
    .o_ifu_inst   (inst),
    .o_ifu_err    (err),
    .i_exu_jmp_en (jmp_en),
    .i_exu_jmp_pc (jmp_pc)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1234_5678;
  endfunction

  // ---------------- imem responder ----------------
  bit          rand_mode = 0;
  int          ar_fixed  = 0;
  int          r_fixed   = 0;
  bit          force_dead = 0;
  logic [31:0] err_addr  = 32'h1;

  initial begin
    bit          have_req = 0;
    bit          ar_armed = 0;
    bit          rand_err = 0;
    int          ar_cnt = 0;
    int          r_cnt = 0;
    logic [31:0] req_addr = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    forever begin
      @(negedge clk);
      arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = $urandom();
      if (!rst_n) begin
        have_req = 0; ar_armed = 0;
      end else begin
        if (!have_req && arvalid) begin
          if (!ar_armed) begin
            ar_cnt   = rand_mode ? int'($urandom_range(0, 3)) : ar_fixed;
            ar_armed = 1;
          end
          if (ar_cnt == 0) arready = 1'b1;
          else ar_cnt--;
        end
        if (have_req) begin
          if (r_cnt == 0) begin
            rvalid = 1'b1;
            rdata  = force_dead ? C_DEAD : mem_word(req_addr);
            if (req_addr == err_addr || rand_err) rresp = 2'b10;
          end else r_cnt--;
        end
      end
      #4;
      if (rst_n) begin
        if (arvalid && arready) begin
          have_req = 1; ar_armed = 0; req_addr = araddr;
          r_cnt    = rand_mode ? int'($urandom_range(0, 3)) : r_fixed;
          rand_err = rand_mode && ($urandom_range(0, 7) == 0);
        end
        if (rvalid && rready) begin
          have_req = 0; force_dead = 0;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } item_t;
  item_t sb[$];
  bit    zero_wait = 0;
  bit    seen_dead = 0;
  int    n_xfer = 0;

  initial begin
    logic [31:0] exp_pc = C_RESET_PC;
    logic [31:0] out_addr = '0;
    bit          outstanding = 0, killed = 0, rpush = 0;
    bit          p_valid = 0, p_ready = 0, p_jmp = 0, p_arvalid = 0, p_arready = 0, p_xfer = 0, p_rpush = 0;
    logic [31:0] p_pc = '0, p_inst = '0, p_araddr = '0;
    logic        p_err = 1'b0;
    int          cyc = 0, last_x = -1;
    item_t       e;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        sb.delete(); outstanding = 0; killed = 0; exp_pc = C_RESET_PC; last_x = -1;
        p_valid = 0; p_arvalid = 0; p_xfer = 0; p_rpush = 0; p_jmp = 0;
        continue;
      end
      cyc++;
      if (p_valid && !p_ready && !p_jmp)
        check(valid && pc == p_pc && inst == p_inst && err == p_err, "out_hold", {valid, pc}, {1'b1, p_pc});
      if (p_arvalid && !p_arready && !p_jmp)
        check(arvalid && araddr == p_araddr, "ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
      if (p_xfer) check(arvalid, "ar_after_xfer", arvalid, 1);
      if (p_rpush) check(valid, "valid_latency", valid, 1);
      if (arvalid) begin
        check(!valid && !rready, "no_overlap", {valid, rready}, 0);
        check(araddr == exp_pc, "araddr", araddr, exp_pc);
      end
      if (valid && inst == C_DEAD) seen_dead = 1;

      p_xfer = 0;
      if (valid && i2i_ready) begin
        p_xfer = 1;
        n_xfer++;
        if (sb.size() == 0) check(0, "sb_underflow", pc, 0);
        else begin
          e = sb.pop_front();
          check(pc == e.pc, "out_pc", pc, e.pc);
          check(inst == e.inst, "out_inst", inst, e.inst);
          check(err == e.err, "out_err", err, e.err);
          exp_pc = e.pc + 32'd4;
        end
        if (zero_wait && last_x >= 0) check(cyc - last_x == 3, "xfer_gap", cyc - last_x, 3);
        last_x = cyc;
      end else if (valid && jmp_en && sb.size() != 0) begin
        void'(sb.pop_front());
      end

      if (arvalid && arready) begin
        outstanding = 1; out_addr = araddr; killed = jmp_en;
      end else if (jmp_en && outstanding) killed = 1;

      rpush = 0;
      if (rvalid && rready) begin
        if (outstanding && !killed && !jmp_en) begin
          sb.push_back('{pc: out_addr, inst: (rresp != 2'b00) ? C_NOP : rdata, err: (rresp != 2'b00)});
          rpush = 1;
        end
        outstanding = 0; killed = 0;
      end
      if (jmp_en) exp_pc = jmp_pc;

      p_valid = valid; p_ready = i2i_ready; p_jmp = jmp_en; p_arvalid = arvalid; p_arready = arready;
      p_pc = pc; p_inst = inst; p_err = err; p_araddr = araddr; p_rpush = rpush;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] tmp;
    int          n0;
    rst_n = 1'b0; i2i_ready = 1'b0; jmp_en = 1'b0; jmp_pc = '0;
    repeat (3) @(negedge clk);
    check({arvalid, rready, valid, err, araddr, pc, inst} == '0, "reset_state", {valid, araddr}, 0);

    // zero-wait sequential fetch
    zero_wait = 1; i2i_ready = 1'b1;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    zero_wait = 0;

    // slow imem
    ar_fixed = 4; r_fixed = 3;
    repeat (40) @(negedge clk);

    // downstream stall in OUT
    ar_fixed = 0; r_fixed = 0; i2i_ready = 1'b0;
    for (int n = 0; n < 30 && !valid; n++) @(negedge clk);
    repeat (5) @(negedge clk);
    check(valid && !arvalid, "stall_hold", {valid, arvalid}, 2'b10);
    i2i_ready = 1'b1;

    // redirect during R, stale response dropped
    r_fixed = 2;
    for (int n = 0; n < 30 && !rready; n++) @(negedge clk);
    force_dead = 1; jmp_en = 1'b1; jmp_pc = 32'h8000_0100;
    @(negedge clk); jmp_en = 1'b0;
    for (int n = 0; n < 30 && !arvalid; n++) @(negedge clk);
    check(arvalid && araddr == 32'h8000_0100, "redir_R_addr", araddr, 32'h8000_0100);
    repeat (15) @(negedge clk);
    check(!seen_dead, "dead_dropped", seen_dead, 0);

    // redirect in OUT with ready in the same cycle
    r_fixed = 0;
    for (int n = 0; n < 30 && !valid; n++) @(negedge clk);
    n0 = n_xfer;
    jmp_en = 1'b1; jmp_pc = 32'h8000_0200;
    @(negedge clk); jmp_en = 1'b0;
    check(arvalid && araddr == 32'h8000_0200, "redir_OUT_addr", araddr, 32'h8000_0200);
    check(n_xfer == n0 + 1, "redir_OUT_xfer", n_xfer, n0 + 1);

    // bus error at 0x8000_0008, then PC wrap
    rst_n = 1'b0;
    @(negedge clk); err_addr = 32'h8000_0008; rst_n = 1'b1;
    for (int n = 0; n < 40 && !(valid && pc == 32'h8000_0008); n++) @(negedge clk);
    check(valid && err && inst == C_NOP, "err_resp", {err, inst}, {1'b1, C_NOP});
    err_addr = 32'h1;
    jmp_en = 1'b1; jmp_pc = 32'hFFFF_FFFC;
    @(negedge clk); jmp_en = 1'b0;
    check(arvalid && araddr == 32'hFFFF_FFFC, "redir_wrap_addr", araddr, 32'hFFFF_FFFC);
    for (int n = 0; n < 40 && !(arvalid && araddr == 32'h0); n++) @(negedge clk);
    check(arvalid && araddr == 32'h0, "pc_wrap", araddr, 0);

    // asynchronous reset in the middle of R
    r_fixed = 3;
    for (int n = 0; n < 30 && !rready; n++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check({arvalid, rready, valid, err, araddr, pc, inst} == '0, "async_reset", {rready, araddr}, 0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1; r_fixed = 0;
    for (int n = 0; n < 30 && !arvalid; n++) @(negedge clk);
    check(arvalid && araddr == C_RESET_PC, "refetch", araddr, C_RESET_PC);

    // randomized traffic
    rand_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      i2i_ready = ($urandom_range(0, 3) != 0);
      jmp_en    = !jmp_en && ($urandom_range(0, 11) == 0);
      tmp       = $urandom();
      jmp_pc    = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFC : {tmp[31:2], 2'b00};
    end
    @(negedge clk); jmp_en = 1'b0; i2i_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
